// File: rtl/gpio_bus_arbiter_pkg.sv
// Shared constants, types and helpers for the GPIO memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gpio_bus_arbiter_pkg;

    localparam int AW = 9;
    localparam int DW = 8;

    // GPIO memory map (top of the 512-byte space)
    localparam logic [AW-1:0] BTN_ADDR = 9'd503;
    localparam logic [AW-1:0] SW_LO    = 9'd504;
    localparam logic [AW-1:0] SW_HI    = 9'd505;
    localparam logic [AW-1:0] LED_LO   = 9'd506;
    localparam logic [AW-1:0] LED_HI   = 9'd507;
    localparam logic [AW-1:0] DIG0     = 9'd508;
    localparam logic [AW-1:0] DIG3     = 9'd511;

    // Buttons and switches are driven by the board, so writes there are dropped
    localparam logic [AW-1:0] RO_LO = BTN_ADDR;
    localparam logic [AW-1:0] RO_HI = SW_HI;

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} gpio_arb_state_t;

    // Fields captured from the winning requester
    typedef struct packed {
        logic          id;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } acc_t;

    // Unsigned, inclusive check against the read-only input window
    function automatic logic is_ro(input logic [AW-1:0] a);
        return (a >= RO_LO) && (a <= RO_HI);
    endfunction

endpackage

// File: rtl/gpio_bus_arbiter_if.sv
// Requester handshake and gpiomem port bundle for the GPIO arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req and fields until gnt.
interface gpio_bus_arbiter_if;
    import gpio_bus_arbiter_pkg::*;

    logic          req0, req1;
    logic          we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1;
    logic          done0, done1;
    logic          err0, err1;
    logic [DW-1:0] rdata;
    logic          mem_rw_select;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out;

    // Arbiter side
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
        output gnt0, gnt1, done0, done1, err0, err1, rdata,
               mem_rw_select, mem_address, mem_data_in
    );

    // Requester / memory side
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
        input  gnt0, gnt1, done0, done1, err0, err1, rdata,
               mem_rw_select, mem_address, mem_data_in
    );

endinterface

// File: rtl/gpio_bus_arbiter_rr_pick.sv
// Two-way round-robin picker: lone requester wins, ties go to rr_ptr.
// Latency: combinational.
// Backpressure: none; caller decides when the pick is consumed.
module gpio_rr_pick (
    input  logic [1:0] req,
    input  logic       rr_ptr,
    output logic       valid,
    output logic       winner
);

    // Resolve the winner from the request pair and the fairness pointer
    always_comb begin
        valid  = |req;
        winner = (&req) ? rr_ptr : req[1];
    end

endmodule

// File: rtl/gpio_bus_arbiter.sv
// Round-robin arbiter and IDLE->ISSUE->DONE sequencer for the 512x8 GPIO memory.
// Latency: req seen in IDLE at T -> gnt at T+1 -> done/rdata at T+2; one access per 3 cycles.
// Backpressure: requests are only sampled in IDLE; a losing requester keeps req high.
module gpio_bus_arbiter
    import gpio_bus_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    gpio_bus_arbiter_if.slave   bus
);

    gpio_arb_state_t state, state_nxt;
    acc_t            lat;
    logic            rr_ptr;
    logic [DW-1:0]   rdata_q;
    logic            pick_vld;
    logic            pick_id;
    logic            ro_hit;

    gpio_rr_pick u_pick (
        .req    ({bus.req1, bus.req0}),
        .rr_ptr (rr_ptr),
        .valid  (pick_vld),
        .winner (pick_id)
    );

    assign ro_hit = is_ro(lat.addr);

    // State register; async reset abandons any in-flight access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: wait for a request, then one cycle each in ISSUE and DONE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = ISSUE;
            ISSUE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the winner's fields and hand priority to the other requester
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat    <= '0;
            rr_ptr <= 1'b0;
        end else if (state == IDLE && pick_vld) begin
            lat.id    <= pick_id;
            lat.we    <= pick_id ? bus.we1    : bus.we0;
            lat.addr  <= pick_id ? bus.addr1  : bus.addr0;
            lat.wdata <= pick_id ? bus.wdata1 : bus.wdata0;
            rr_ptr    <= ~pick_id;
        end
    end

    // Memory output is sampled at the end of ISSUE and held until the next access
    always_ff @(posedge clk or posedge reset) begin
        if (reset)               rdata_q <= '0;
        else if (state == ISSUE) rdata_q <= bus.mem_data_out;
    end

    // Output decode from state and latched fields; strobe only in ISSUE, never into RO window
    always_comb begin
        bus.gnt0          = 1'b0;
        bus.gnt1          = 1'b0;
        bus.done0         = 1'b0;
        bus.done1         = 1'b0;
        bus.err0          = 1'b0;
        bus.err1          = 1'b0;
        bus.mem_rw_select = 1'b0;
        bus.mem_address   = lat.addr;
        bus.mem_data_in   = lat.wdata;
        bus.rdata         = rdata_q;
        case (state)
            ISSUE: begin
                bus.gnt0          = ~lat.id;
                bus.gnt1          =  lat.id;
                bus.mem_rw_select = lat.we & ~ro_hit;
            end
            DONE: begin
                bus.done0 = ~lat.id;
                bus.done1 =  lat.id;
                bus.err0  = ~lat.id & lat.we & ro_hit;
                bus.err1  =  lat.id & lat.we & ro_hit;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Directed bench for gpio_bus_arbiter with a 512x8 memory model and a completion scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_gpio_bus_arbiter;
    import gpio_bus_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic mem_init;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    gpio_bus_arbiter_if bus();

    gpio_bus_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory model: asynchronous read, synchronous write
    logic [7:0] mem [0:511];
    logic [7:0] leds;
    assign bus.mem_data_out = mem[bus.mem_address];
    assign leds = mem[LED_LO];

    function automatic logic [7:0] exp_init(input logic [8:0] a);
        if (a == 9'd6) return 8'h2A;
        if (is_ro(a))  return 8'h00;
        return a[7:0] ^ 8'h5C;
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 512; i++) mem[i] <= exp_init(i[8:0]);
        end else if (bus.mem_rw_select) begin
            mem[bus.mem_address] <= bus.mem_data_in;
        end
    end

    typedef struct {
        bit         who;
        bit         err;
        bit         chk;
        logic [7:0] rd;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Per-cycle invariants and scoreboard pop on every completion
    always @(negedge clk) begin
        if (!reset && !mem_init) begin
            check("rw_only_in_issue", {31'b0, bus.mem_rw_select & ~(bus.gnt0 | bus.gnt1)}, 0);
            check("rw_not_ro", {31'b0, bus.mem_rw_select & is_ro(bus.mem_address)}, 0);
            check("onehot", {31'b0, (bus.gnt0 & bus.gnt1) | (bus.done0 & bus.done1) | (bus.err0 & bus.err1)}, 0);
            if (bus.done0 | bus.done1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_id", {30'b0, bus.done1, bus.done0}, e.who ? 2 : 1);
                    check("err", {30'b0, bus.err1, bus.err0}, e.err ? (e.who ? 2 : 1) : 0);
                    if (e.chk) check("rdata", bus.rdata, e.rd);
                end
            end
        end
    end

    task automatic drive(input bit who, input bit r, input bit we, input logic [8:0] a, input logic [7:0] d);
        if (who) begin
            bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
        end else begin
            bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
        end
    endtask

    // Waits (bounded) for a grant; returns the number of negedges it took
    task automatic wait_gnt(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.gnt0 | bus.gnt1) && n < 8);
        if (!(bus.gnt0 | bus.gnt1)) check("gnt_timeout", 0, 1);
    endtask

    // One complete single-requester access with all handshake checks
    task automatic access(input bit who, input bit we, input logic [8:0] a, input logic [7:0] d, input logic [7:0] exp_rd);
        exp_t e;
        int   n;
        bit   ro;
        ro    = is_ro(a);
        e.who = who; e.err = we & ro; e.chk = ~we; e.rd = exp_rd;
        sb.push_back(e);
        @(negedge clk);
        drive(who, 1'b1, we, a, d);
        wait_gnt(n);
        check("gnt_latency", n, 1);
        check("gnt_id", {30'b0, bus.gnt1, bus.gnt0}, who ? 2 : 1);
        check("issue_rw", {31'b0, bus.mem_rw_select}, {31'b0, we & ~ro});
        check("issue_addr", {23'b0, bus.mem_address}, {23'b0, a});
        if (we) check("issue_wdata", {24'b0, bus.mem_data_in}, {24'b0, d});
        drive(who, 1'b0, 1'b0, 9'd0, 8'd0);
        @(negedge clk);
        check("done_latency", {31'b0, bus.done0 | bus.done1}, 1);
        check("done_rw_low", {31'b0, bus.mem_rw_select}, 0);
        check("done_addr", {23'b0, bus.mem_address}, {23'b0, a});
    endtask

    // Both requesters read continuously; grants must alternate starting with requester 0
    task automatic contend(input int grants);
        exp_t e;
        int   n;
        for (int k = 0; k < grants; k++) begin
            e.who = k[0]; e.err = 1'b0; e.chk = 1'b1;
            e.rd  = exp_init(k[0] ? 9'd20 : 9'd10);
            sb.push_back(e);
        end
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 9'd10, 8'd0);
        drive(1'b1, 1'b1, 1'b0, 9'd20, 8'd0);
        for (int k = 0; k < grants; k++) begin
            wait_gnt(n);
            check("rr_order", {30'b0, bus.gnt1, bus.gnt0}, k[0] ? 2 : 1);
            check("rr_rate", n, (k == 0) ? 1 : 3);
            if (k == grants - 1) begin
                drive(1'b0, 1'b0, 1'b0, 9'd0, 8'd0);
                drive(1'b1, 1'b0, 1'b0, 9'd0, 8'd0);
            end
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
        mem_init = 1'b1;
        reset    = 1'b1;
        repeat (2) @(negedge clk);
        mem_init = 1'b0;

        // Reset state
        check("reset_outs", {17'b0, bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err0, bus.err1,
                             bus.mem_rw_select, bus.rdata}, 0);
        check("reset_addr", {23'b0, bus.mem_address}, 0);
        check("reset_din", {24'b0, bus.mem_data_in}, 0);
        check("reset_state", {30'b0, dut.state}, {30'b0, IDLE});
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Contention right after reset: requester 0 first, then alternate
        contend(4);

        // Simple read
        access(1'b0, 1'b0, 9'd6, 8'h00, 8'h2A);

        // Write LEDs from requester 1, then read back
        access(1'b1, 1'b1, LED_LO, 8'hA5, 8'h00);
        check("leds", {24'b0, leds}, 32'hA5);
        access(1'b0, 1'b0, LED_LO, 8'h00, 8'hA5);

        // Write to switches is suppressed and flagged
        access(1'b0, 1'b1, SW_LO, 8'hFF, 8'h00);
        access(1'b0, 1'b0, SW_LO, 8'h00, 8'h00);

        // Boundary addresses
        access(1'b0, 1'b0, 9'd502, 8'h00, exp_init(9'd502));
        access(1'b1, 1'b0, 9'd511, 8'h00, exp_init(9'd511));
        access(1'b0, 1'b1, 9'd502, 8'h3C, 8'h00);
        access(1'b1, 1'b0, 9'd502, 8'h00, 8'h3C);
        access(1'b1, 1'b1, LED_LO, 8'h5A, 8'h00);
        access(1'b0, 1'b0, LED_LO, 8'h00, 8'h5A);
        access(1'b1, 1'b1, BTN_ADDR, 8'h11, 8'h00);
        access(1'b0, 1'b1, SW_HI, 8'h22, 8'h00);
        access(1'b1, 1'b0, BTN_ADDR, 8'h00, 8'h00);
        access(1'b0, 1'b0, SW_HI, 8'h00, 8'h00);

        // Reset in the middle of a write to 508
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, DIG0, 8'h77);
        @(negedge clk);
        check("mid_gnt", {31'b0, bus.gnt0}, 1);
        check("mid_rw_high", {31'b0, bus.mem_rw_select}, 1);
        drive(1'b0, 1'b0, 1'b0, 9'd0, 8'd0);
        #1 reset = 1'b1;
        #1;
        check("mid_rw_drop", {31'b0, bus.mem_rw_select}, 0);
        check("mid_state", {30'b0, dut.state}, {30'b0, IDLE});
        check("mid_gnt_drop", {31'b0, bus.gnt0}, 0);
        repeat (3) begin
            @(negedge clk);
            check("mid_no_done", {30'b0, bus.done1, bus.done0}, 0);
        end
        reset = 1'b0;
        @(negedge clk);
        check("mid_no_write", {24'b0, mem[DIG0]}, {24'b0, exp_init(DIG0)});
        contend(2);

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
